// File: rtl/fetch_pc_if.sv
// Request/response bundle between the fetch controller and the PC generator.
interface fetch_pc_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            jmp;
    logic            rel;
    logic [XLEN-1:0] nxt;
    logic            trap;
    logic [XLEN-1:0] tvec;
    logic            call;
    logic            ret;
    logic [XLEN-1:0] cur;
    logic            misalign;
    logic [XLEN-1:0] badaddr;
    logic            ras_empty;

    modport master (
        output stall, jmp, rel, nxt, trap, tvec, call, ret,
        input  cur, misalign, badaddr, ras_empty
    );

    modport slave (
        input  stall, jmp, rel, nxt, trap, tvec, call, ret,
        output cur, misalign, badaddr, ras_empty
    );
endinterface

// File: rtl/fetch_pc.sv
// Program-counter generator with trap/jump redirect and misaligned-target capture.
// Define FETCH_PC_RAS_EN to build in the circular return-address stack (call/ret).
module fetch_pc #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    fetch_pc_if.slave bus
);

    localparam logic [XLEN-1:0] STEP = XLEN'(4);

    logic [XLEN-1:0] cur_q, cur_d;
    logic [XLEN-1:0] badaddr_q, badaddr_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;
    logic            redirect;

    assign seq_pc = cur_q + STEP;

`ifdef FETCH_PC_RAS_EN
    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  ras_q [RAS_DEPTH];
    logic [XLEN-1:0]  ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [PTR_W-1:0] push_ptr;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ras_empty_q, ras_empty_d;
    logic             push;
    logic             pop;

    // A call only counts when it rides on a jump; pops need a live entry.
    assign push     = bus.jmp && bus.call;
    assign pop      = bus.ret && (cnt_q != '0);
    assign push_ptr = top_q + PTR_ONE;
`else
    logic unused_ras;
    assign unused_ras = bus.call ^ bus.ret;
`endif

    always_comb begin
        cur_d      = seq_pc;
        misalign_d = 1'b0;
        badaddr_d  = badaddr_q;
        target     = '0;
        redirect   = 1'b0;
`ifdef FETCH_PC_RAS_EN
        ras_d      = ras_q;
        top_d      = top_q;
        cnt_d      = cnt_q;
`endif
        if (rst) begin
            cur_d     = RESET_VEC;
            badaddr_d = '0;
`ifdef FETCH_PC_RAS_EN
            top_d     = '0;
            cnt_d     = '0;
`endif
        end else if (bus.trap) begin
            cur_d = bus.tvec;
        end else if (bus.stall) begin
            cur_d = cur_q;
        end else begin
`ifdef FETCH_PC_RAS_EN
            // Call+ret swaps the top for the new return address instead of pop-then-push.
            if (pop) begin
                redirect = 1'b1;
                target   = ras_q[top_q];
                if (push) begin
                    ras_d[top_q] = seq_pc;
                end else begin
                    top_d = top_q - PTR_ONE;
                    cnt_d = cnt_q - CNT_ONE;
                end
            end else
`endif
            if (bus.jmp) begin
                redirect = 1'b1;
                target   = bus.rel ? (cur_q + bus.nxt) : bus.nxt;
`ifdef FETCH_PC_RAS_EN
                if (push) begin
                    top_d           = push_ptr;
                    ras_d[push_ptr] = seq_pc;
                    if (cnt_q != CNT_FULL) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
`endif
            end

            // A misaligned target is never fetched; it diverts to the trap vector instead.
            if (redirect) begin
                if (target[1:0] != 2'b00) begin
                    cur_d      = bus.tvec;
                    badaddr_d  = target;
                    misalign_d = 1'b1;
                end else begin
                    cur_d = target;
                end
            end
        end
`ifdef FETCH_PC_RAS_EN
        ras_empty_d = (cnt_d == '0);
`endif
    end

    always_ff @(posedge clk) begin
        cur_q       <= cur_d;
        misalign_q  <= misalign_d;
        badaddr_q   <= badaddr_d;
`ifdef FETCH_PC_RAS_EN
        ras_q       <= ras_d;
        top_q       <= top_d;
        cnt_q       <= cnt_d;
        ras_empty_q <= ras_empty_d;
`endif
    end

    assign bus.cur      = cur_q;
    assign bus.misalign = misalign_q;
    assign bus.badaddr  = badaddr_q;
`ifdef FETCH_PC_RAS_EN
    assign bus.ras_empty = ras_empty_q;
`else
    assign bus.ras_empty = 1'b1;
`endif

endmodule
